// File: rtl/crop_border.sv
// rtl/crop_border.sv - strips the reflected border from the extended frame buffer
// Reads the interior of the extended buffer in raster order and writes a packed frame.
module crop_border #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BORDER = 19,
  parameter int W_EXT  = 678,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  din,
  output logic [18:0] addr_rd,
  output logic [7:0]  dout,
  output logic [18:0] addr_wr,
  output logic        wren,
  output logic        busy,
  output logic        done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [18:0] START_ADDR = 19'(BORDER * W_EXT + BORDER);
  localparam logic [18:0] ROW_STEP   = 19'(2 * BORDER + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [2:0]    D_LAST   = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nx;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [2:0]         dcnt;
  logic [RD_LAT-1:0]  vpipe;
  logic [18:0]        wcnt;
  logic               issue;
  logic               last_rd;
  logic               tap;

  assign last_rd = (x == X_LAST) && (y == Y_LAST);
  assign tap     = vpipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_rd) state_nx = DRAIN;
      DRAIN:   if (dcnt == D_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    issue = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_rd <= '0;
      addr_wr <= '0;
      dout    <= '0;
      wren    <= 1'b0;
      done    <= 1'b0;
      x       <= '0;
      y       <= '0;
      dcnt    <= '0;
      vpipe   <= '0;
      wcnt    <= '0;
    end else begin
      done <= (state == DRAIN) && (dcnt == D_LAST);
      // Each issued read matures RD_LAT cycles later into one write.
      vpipe[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
      wren <= tap;
      if (tap) begin
        dout    <= din;
        addr_wr <= wcnt;
        wcnt    <= wcnt + 19'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr_rd <= START_ADDR;
            x       <= '0;
            y       <= '0;
            wcnt    <= '0;
            dcnt    <= '0;
          end
        end
        RUN: begin
          if (x != X_LAST) begin
            x       <= x + 1'b1;
            addr_rd <= addr_rd + 19'd1;
          end else if (y != Y_LAST) begin
            x       <= '0;
            y       <= y + 1'b1;
            addr_rd <= addr_rd + ROW_STEP;
          end
          dcnt <= '0;
        end
        DRAIN:   dcnt <= dcnt + 3'd1;
        default: dcnt <= '0;
      endcase
    end
  end

endmodule
